// File: rtl/fp_mul_pkg.sv
// Shared helpers for the pipelined floating-point multiplier: field extraction,
// status-flag bundle and special-value constructors for any EXP_W/MAN_W.
package fp_mul_pkg;

  localparam int FP_MAX_W = 64;

  typedef logic [FP_MAX_W-1:0] fp_word_t;

  typedef struct packed {
    logic exception;
    logic overflow;
    logic underflow;
    logic zero;
  } fp_flags_t;

  // Helpers work on a wide container word; callers truncate to their own widths.
  function automatic logic fp_sign(fp_word_t x, int exp_w, int man_w);
    fp_word_t t;
    t = x >> (exp_w + man_w);
    return t[0];
  endfunction

  function automatic fp_word_t fp_exp(fp_word_t x, int exp_w, int man_w);
    return (x >> man_w) & ((fp_word_t'(1) << exp_w) - fp_word_t'(1));
  endfunction

  function automatic fp_word_t fp_man(fp_word_t x, int man_w);
    return x & ((fp_word_t'(1) << man_w) - fp_word_t'(1));
  endfunction

  function automatic fp_word_t fp_nan(int exp_w, int man_w);
    return (((fp_word_t'(1) << exp_w) - fp_word_t'(1)) << man_w) |
           (fp_word_t'(1) << (man_w - 1));
  endfunction

  function automatic fp_word_t fp_inf(logic sign, int exp_w, int man_w);
    return (fp_word_t'(sign) << (exp_w + man_w)) |
           (((fp_word_t'(1) << exp_w) - fp_word_t'(1)) << man_w);
  endfunction

  function automatic fp_word_t fp_zero(logic sign, int exp_w, int man_w);
    return fp_word_t'(sign) << (exp_w + man_w);
  endfunction

endpackage

// File: rtl/fp_mul_pipe_round.sv
// Normalise a raw significand product and round it to nearest-even.
// exp_o carries the normalisation adjustment only; the caller adds carry_o.
module fp_round_rne #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 10
) (
  input  logic        [2*MAN_W+1:0] prod_i,
  input  logic signed [EXP_W+1:0]   exp_i,
  output logic        [MAN_W-1:0]   man_o,
  output logic signed [EXP_W+1:0]   exp_o,
  output logic                      carry_o
);

  localparam int PW = 2 * MAN_W + 2;

  logic             n;
  logic [PW-2:0]    norm;
  logic [MAN_W-1:0] kept;
  logic             guard;
  logic             sticky;
  logic             inc;
  logic [MAN_W:0]   sum;

  always_comb begin
    n       = prod_i[PW-1];
    // Drop the hidden bit; norm holds fraction bits only.
    norm    = n ? prod_i[PW-2:0] : {prod_i[PW-3:0], 1'b0};
    kept    = norm[PW-2 -: MAN_W];
    guard   = norm[MAN_W];
    sticky  = |norm[MAN_W-1:0];
    inc     = guard & (sticky | kept[0]);
    sum     = {1'b0, kept} + {{MAN_W{1'b0}}, inc};
    carry_o = sum[MAN_W];
    man_o   = sum[MAN_W-1:0];
    exp_o   = exp_i + $signed({{(EXP_W+1){1'b0}}, n});
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage floating-point multiplier with global-stall valid/ready handshake,
// round-to-nearest-even, flush-to-zero inputs and IEEE-style specials.
module fp_mul_pipe
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   exception,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   zero
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EW2  = EXP_W + 2;
  localparam int PW   = 2 * MAN_W + 2;

  logic en;

  logic                  vld_p1_q, vld_p2_q;
  logic                  out_valid_q;
  logic [W-1:0]          result_q, result_d;
  fp_flags_t             flags_q, flags_d;

  logic                  sgn_p1_d, exc_p1_d, zro_p1_d;
  logic [EXP_W-1:0]      exp_a, exp_b;
  logic [MAN_W-1:0]      man_a, man_b;
  logic signed [EW2-1:0] esum_p1_d;

  logic                  sgn_p1_q, exc_p1_q, zro_p1_q;
  logic signed [EW2-1:0] esum_p1_q;
  logic [MAN_W-1:0]      mana_p1_q, manb_p1_q;

  logic [PW-1:0]         prod_p2_d;
  logic                  sgn_p2_q, exc_p2_q, zro_p2_q;
  logic signed [EW2-1:0] esum_p2_q;
  logic [PW-1:0]         prod_p2_q;

  logic [MAN_W-1:0]      rman;
  logic signed [EW2-1:0] rexp, efin;
  logic                  rcarry;

  assign en       = !out_valid_q | out_ready;
  assign in_ready = en;

  // ---- S1: decode, classify, exponent sum
  always_comb begin
    exp_a     = EXP_W'(fp_exp(fp_word_t'(a), EXP_W, MAN_W));
    exp_b     = EXP_W'(fp_exp(fp_word_t'(b), EXP_W, MAN_W));
    man_a     = MAN_W'(fp_man(fp_word_t'(a), MAN_W));
    man_b     = MAN_W'(fp_man(fp_word_t'(b), MAN_W));
    sgn_p1_d  = fp_sign(fp_word_t'(a), EXP_W, MAN_W) ^ fp_sign(fp_word_t'(b), EXP_W, MAN_W);
    exc_p1_d  = (exp_a == '1) | (exp_b == '1);
    zro_p1_d  = (exp_a == '0) | (exp_b == '0);
    esum_p1_d = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - $signed(EW2'(BIAS));
  end

  // ---- S2: significand product
  assign prod_p2_d = PW'({1'b1, mana_p1_q}) * PW'({1'b1, manb_p1_q});

  // ---- S3: normalise, round, range check, pack
  fp_round_rne #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round (
    .prod_i  (prod_p2_q),
    .exp_i   (esum_p2_q),
    .man_o   (rman),
    .exp_o   (rexp),
    .carry_o (rcarry)
  );

  assign efin = rexp + $signed({{(EW2-1){1'b0}}, rcarry});

  always_comb begin
    result_d = '0;
    flags_d  = '0;
    if (exc_p2_q) begin
      result_d          = W'(fp_nan(EXP_W, MAN_W));
      flags_d.exception = 1'b1;
    end else if (zro_p2_q) begin
      result_d     = W'(fp_zero(sgn_p2_q, EXP_W, MAN_W));
      flags_d.zero = 1'b1;
    end else if (efin >= $signed(EW2'((1 << EXP_W) - 1))) begin
      result_d         = W'(fp_inf(sgn_p2_q, EXP_W, MAN_W));
      flags_d.overflow = 1'b1;
    end else if (efin <= $signed(EW2'(0))) begin
      result_d          = W'(fp_zero(sgn_p2_q, EXP_W, MAN_W));
      flags_d.underflow = 1'b1;
    end else begin
      result_d = {sgn_p2_q, efin[EXP_W-1:0], rman};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else if (en) begin
      vld_p1_q    <= in_valid;
      vld_p2_q    <= vld_p1_q;
      out_valid_q <= vld_p2_q;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  // Datapath stages carry no reset; their contents are qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (en) begin
      sgn_p1_q  <= sgn_p1_d;
      exc_p1_q  <= exc_p1_d;
      zro_p1_q  <= zro_p1_d;
      esum_p1_q <= esum_p1_d;
      mana_p1_q <= man_a;
      manb_p1_q <= man_b;
      sgn_p2_q  <= sgn_p1_q;
      exc_p2_q  <= exc_p1_q;
      zro_p2_q  <= zro_p1_q;
      esum_p2_q <= esum_p1_q;
      prod_p2_q <= prod_p2_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign exception = flags_q.exception;
  assign overflow  = flags_q.overflow;
  assign underflow = flags_q.underflow;
  assign zero      = flags_q.zero;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed bench for fp_mul_pipe at EXP_W=8, MAN_W=10: specials, RNE tie,
// latency, back-pressure against an arithmetic reference, async reset.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [18:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [18:0] result;
  logic        exception, overflow, underflow, zero;
  logic [3:0]  fl;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign fl = {exception, overflow, underflow, zero};

  fp_mul_pipe #(.EXP_W(8), .MAN_W(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .exception (exception),
    .overflow  (overflow),
    .underflow (underflow),
    .zero      (zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {exception, overflow, underflow, zero, result[18:0]}.
  function automatic logic [22:0] ref_mul(input logic [18:0] x, input logic [18:0] y);
    int     ea, eb, e, sh;
    longint ma, mb, p, mant, rem, half;
    logic   s;
    s  = x[18] ^ y[18];
    ea = int'(x[17:10]);
    eb = int'(y[17:10]);
    if (ea == 255 || eb == 255) return {4'b1000, 19'h3FE00};
    if (ea == 0 || eb == 0) return {4'b0001, s, 18'h0};
    ma = 1024 + longint'(x[9:0]);
    mb = 1024 + longint'(y[9:0]);
    p  = ma * mb;
    e  = ea + eb - 127;
    if (p >= 64'd2097152) begin sh = 11; e = e + 1; end
    else sh = 10;
    mant = p >> sh;
    rem  = p - (mant << sh);
    half = longint'(1) << (sh - 1);
    if (rem > half || (rem == half && mant[0])) mant = mant + 1;
    if (mant == 2048) begin mant = 1024; e = e + 1; end
    if (e >= 255) return {4'b0100, s, 8'hFF, 10'h0};
    if (e <= 0) return {4'b0010, s, 18'h0};
    return {4'b0000, s, e[7:0], mant[9:0]};
  endfunction

  task automatic run_one(input string tag, input logic [18:0] xa, input logic [18:0] xb,
                         input logic [18:0] er, input logic [3:0] ef);
    a = xa; b = xb; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_lat2"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_result"}, 32'(result), 32'(er));
    chk({tag, "_flags"}, 32'(fl), 32'(ef));
    @(posedge clk); #1;
  endtask

  logic [18:0] va[8], vb[8];
  logic [22:0] ev[8];
  logic [3:0]  pat;
  logic [22:0] held_val;
  logic        held, in_f, out_f;
  int          sent, recv;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_flags", 32'(fl), 32'd0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    run_one("mul_1p5x1p5", 19'h1FE00, 19'h1FE00, 19'h20080, 4'b0000);
    run_one("mul_2xm2",    19'h20000, 19'h60000, 19'h60400, 4'b0000);
    run_one("rne_tie",     19'h1FC01, 19'h1FE00, 19'h1FE02, 4'b0000);
    run_one("overflow",    19'h3C000, 19'h3C000, 19'h3FC00, 4'b0100);
    run_one("underflow",   19'h04000, 19'h04000, 19'h00000, 4'b0010);
    run_one("nan_in",      19'h3FC00, 19'h1FE00, 19'h3FE00, 4'b1000);
    run_one("zero_in",     19'h00123, 19'h60000, 19'h40000, 4'b0001);

    // Back-pressure stream with out_ready pattern 1,0,0,1 repeating.
    for (int i = 0; i < 8; i++) begin
      va[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 10'($urandom_range(0, 1023))};
      vb[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 10'($urandom_range(0, 1023))};
      ev[i] = ref_mul(va[i], vb[i]);
    end
    pat = 4'b1001;
    sent = 0; recv = 0; held = 1'b0; held_val = '0;
    for (int cyc = 0; cyc < 200 && recv < 8; cyc++) begin
      out_ready = pat[cyc % 4];
      in_valid  = (sent < 8);
      a = va[3'(sent < 8 ? sent : 7)];
      b = vb[3'(sent < 8 ? sent : 7)];
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'(!out_valid | out_ready));
      if (held) chk("bp_stable", 32'({fl, result}), 32'(held_val));
      in_f  = in_valid & in_ready;
      out_f = out_valid & out_ready;
      if (out_f) begin
        chk("bp_result", 32'(result), 32'(ev[3'(recv)][18:0]));
        chk("bp_flags", 32'(fl), 32'(ev[3'(recv)][22:19]));
        recv++;
      end
      held     = out_valid & !out_ready;
      held_val = {fl, result};
      @(posedge clk); #1;
      if (in_f) sent++;
    end
    chk("bp_all_received", 32'(recv), 32'd8);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Reset with three operations in flight.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = va[3'(i)]; b = vb[3'(i)];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("rst_pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 32'(out_valid), 32'd0);
    chk("rst_async_result", 32'(result), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rst_no_stale", 32'(out_valid), 32'd0);
    end
    run_one("post_rst", 19'h1FE00, 19'h1FE00, 19'h20080, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
